// File: rtl/tilt_to_move_if.sv
// Sample-in / step-out bundle between the accelerometer front end, tilt_to_move and the ball.
interface tilt_to_move_if #(
    parameter int unsigned ACCEL_WIDTH = 12
);
    logic                   enable;
    logic                   sample_valid;
    logic [ACCEL_WIDTH-1:0] accel_x;
    logic [ACCEL_WIDTH-1:0] accel_y;
    logic [3:0]             movement;
    logic [7:0]             debug;

    modport master (output enable, sample_valid, accel_x, accel_y, input movement, debug);
    modport slave  (input enable, sample_valid, accel_x, accel_y, output movement, debug);
endinterface

// File: rtl/tilt_to_move.sv
// Converts signed tilt samples into rate-limited, one-hot ball step pulses with
// per-axis deadzone, magnitude-to-rate mapping and alternating X/Y arbitration.
module tilt_to_move #(
    parameter int unsigned ACCEL_WIDTH          = 12,
    parameter int unsigned DEADZONE             = 64,
    parameter int unsigned LEVEL_SHIFT          = 7,
    parameter int unsigned TICK_CYCLES          = 100000,
    parameter int unsigned SIMULATE             = 0,
    parameter int unsigned SIMULATE_TICK_CYCLES = 5,
    parameter int unsigned MAX_INTERVAL         = 32,
    parameter int unsigned MIN_GAP              = 128,
    parameter int unsigned INVERT_X             = 0,
    parameter int unsigned INVERT_Y             = 0
) (
    input logic           clk,
    input logic           reset,
    tilt_to_move_if.slave bus
);
    localparam int unsigned TICKS = (SIMULATE != 0) ? SIMULATE_TICK_CYCLES : TICK_CYCLES;
    localparam int unsigned PW    = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam int unsigned CW    = $clog2(MAX_INTERVAL + 1);
    localparam int unsigned GW    = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
    localparam bit          INV_X = (INVERT_X != 0);
    localparam bit          INV_Y = (INVERT_Y != 0);

    typedef enum logic {IDLE, GAP} arb_state_t;

    // Axis index 0 = X, 1 = Y throughout.
    logic [1:0][ACCEL_WIDTH-1:0] smp;
    logic [1:0][ACCEL_WIDTH-1:0] mag;
    logic [1:0][ACCEL_WIDTH-1:0] over;
    logic [1:0][ACCEL_WIDTH-1:0] steps;
    logic [1:0]                  dead;
    logic [1:0][1:0]             level;
    logic [1:0][CW-1:0]          interval;
    logic [1:0][CW-1:0]          cnt, cnt_next, cnt_inc;
    logic [1:0]                  pend, pend_next;
    logic [1:0]                  dir, dir_next;
    logic [1:0]                  live_valid, live_valid_next;
    logic [1:0]                  live_sign, live_sign_next;
    logic [PW-1:0]               presc;
    logic                        tick;
    arb_state_t                  state, state_next;
    logic [GW-1:0]               gap_cnt, gap_next;
    logic                        last_axis, last_axis_next;
    logic                        emit, emit_axis;
    logic [1:0]                  emit_mask;

    assign tick = bus.enable && (presc == PW'(TICKS - 1));

    always_comb begin
        for (int unsigned i = 0; i < 2; i++) begin
            mag[i]      = smp[i][ACCEL_WIDTH-1] ? ((~smp[i]) + ACCEL_WIDTH'(1)) : smp[i];
            dead[i]     = (mag[i] <= ACCEL_WIDTH'(DEADZONE));
            over[i]     = mag[i] - ACCEL_WIDTH'(DEADZONE);
            steps[i]    = over[i] >> LEVEL_SHIFT;
            level[i]    = dead[i] ? 2'd0 : ((steps[i] > ACCEL_WIDTH'(3)) ? 2'd3 : steps[i][1:0]);
            interval[i] = CW'(MAX_INTERVAL >> level[i]);
            cnt_inc[i]  = cnt[i] + CW'(1);
        end
    end

    // Per-axis rate counters; the emitted axis's clear overrides any same-cycle set.
    always_comb begin
        cnt_next        = cnt;
        pend_next       = pend;
        dir_next        = dir;
        live_valid_next = live_valid;
        live_sign_next  = live_sign;
        for (int unsigned i = 0; i < 2; i++) begin
            if (!bus.enable) begin
                cnt_next[i]        = '0;
                pend_next[i]       = 1'b0;
                dir_next[i]        = 1'b0;
                live_valid_next[i] = 1'b0;
                live_sign_next[i]  = 1'b0;
            end else if (tick) begin
                if (dead[i]) begin
                    cnt_next[i]        = '0;
                    pend_next[i]       = 1'b0;
                    live_valid_next[i] = 1'b0;
                end else begin
                    live_valid_next[i] = 1'b1;
                    live_sign_next[i]  = smp[i][ACCEL_WIDTH-1];
                    if (live_valid[i] && (live_sign[i] != smp[i][ACCEL_WIDTH-1])) begin
                        cnt_next[i]  = CW'(1);
                        pend_next[i] = 1'b0;
                    end else if (cnt_inc[i] >= interval[i]) begin
                        cnt_next[i]  = '0;
                        pend_next[i] = 1'b1;
                        dir_next[i]  = smp[i][ACCEL_WIDTH-1];
                    end else begin
                        cnt_next[i]  = cnt_inc[i];
                    end
                end
            end
        end
        pend_next = pend_next & ~emit_mask;
    end

    always_comb begin
        state_next     = state;
        gap_next       = gap_cnt;
        last_axis_next = last_axis;
        emit           = 1'b0;
        emit_axis      = 1'b0;
        emit_mask      = 2'b00;
        bus.movement   = '0;
        case (state)
            IDLE: begin
                if (bus.enable && (pend != 2'b00)) begin
                    emit           = 1'b1;
                    emit_axis      = (pend == 2'b11) ? ~last_axis : pend[1];
                    emit_mask      = emit_axis ? 2'b10 : 2'b01;
                    last_axis_next = emit_axis;
                    state_next     = GAP;
                    gap_next       = '0;
                    if (!emit_axis)
                        bus.movement = (dir[0] ^ INV_X) ? 4'b0100 : 4'b1000;
                    else
                        bus.movement = (dir[1] ^ INV_Y) ? 4'b0001 : 4'b0010;
                end
            end
            GAP: begin
                if (gap_cnt == GW'(MIN_GAP - 1))
                    state_next = IDLE;
                else
                    gap_next = gap_cnt + GW'(1);
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.debug = {level[0], level[1], pend[0], pend[1], last_axis, (state == GAP)};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            gap_cnt   <= '0;
            last_axis <= 1'b0;
        end else begin
            state     <= state_next;
            gap_cnt   <= gap_next;
            last_axis <= last_axis_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            smp        <= '0;
            presc      <= '0;
            cnt        <= '0;
            pend       <= '0;
            dir        <= '0;
            live_valid <= '0;
            live_sign  <= '0;
        end else begin
            if (bus.sample_valid) begin
                smp[0] <= bus.accel_x;
                smp[1] <= bus.accel_y;
            end
            if (!bus.enable || tick)
                presc <= '0;
            else
                presc <= presc + PW'(1);
            cnt        <= cnt_next;
            pend       <= pend_next;
            dir        <= dir_next;
            live_valid <= live_valid_next;
            live_sign  <= live_sign_next;
        end
    end
endmodule

// File: tb/tb_tilt_to_move.sv
// Randomized and directed checks of tilt_to_move against a timestamp-based behavioural model.
module tb_tilt_to_move;
    localparam int TICKS = 5;
    localparam int DZ    = 64;
    localparam int LS    = 7;
    localparam int MAXI  = 32;
    localparam int GAPC  = 128;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    tilt_to_move_if #(.ACCEL_WIDTH(12)) bus ();

    tilt_to_move #(.SIMULATE(1), .SIMULATE_TICK_CYCLES(TICKS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Model state: samples as ints, per-axis tick counts, and the earliest cycle a pulse may issue.
    int m_s[2];
    int m_cnt[2];
    int m_prev[2];
    int m_dir[2];
    bit m_pend[2];
    int m_pre;
    int m_last;
    int cyc = 0;
    int next_ok;

    function automatic int mag(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int lvl(input int v);
        int e;
        if (mag(v) <= DZ) return 0;
        e = (mag(v) - DZ) >> LS;
        return (e > 3) ? 3 : e;
    endfunction

    function automatic int pick();
        if (!bus.enable || cyc < next_ok) return -1;
        if (m_pend[0] && m_pend[1]) return (m_last == 0) ? 1 : 0;
        if (m_pend[0]) return 0;
        if (m_pend[1]) return 1;
        return -1;
    endfunction

    function automatic logic [3:0] exp_mov();
        int a;
        a = pick();
        if (a < 0) return 4'b0000;
        if (a == 0) return (m_dir[0] < 0) ? 4'b0100 : 4'b1000;
        return (m_dir[1] < 0) ? 4'b0001 : 4'b0010;
    endfunction

    function automatic logic [7:0] exp_dbg();
        return {2'(lvl(m_s[0])), 2'(lvl(m_s[1])), m_pend[0], m_pend[1], 1'(m_last), (cyc < next_ok)};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            m_s[i] = 0; m_cnt[i] = 0; m_prev[i] = 0; m_dir[i] = 0; m_pend[i] = 1'b0;
        end
        m_pre = 0; m_last = 0; next_ok = 0;
    endtask

    task automatic model_update();
        int a;
        bit tk;
        if (!reset) begin
            cyc++;
            return;
        end
        a  = pick();
        tk = bus.enable && (m_pre == TICKS - 1);
        for (int i = 0; i < 2; i++) begin
            int v;
            int s;
            v = m_s[i];
            s = (v < 0) ? -1 : 1;
            if (!bus.enable) begin
                m_cnt[i] = 0; m_pend[i] = 1'b0; m_prev[i] = 0;
            end else if (tk) begin
                if (mag(v) <= DZ) begin
                    m_cnt[i] = 0; m_pend[i] = 1'b0; m_prev[i] = 0;
                end else begin
                    if (m_prev[i] != 0 && m_prev[i] != s) begin
                        m_cnt[i] = 1; m_pend[i] = 1'b0;
                    end else if (m_cnt[i] + 1 >= (MAXI >> lvl(v))) begin
                        m_cnt[i] = 0; m_pend[i] = 1'b1; m_dir[i] = s;
                    end else begin
                        m_cnt[i] = m_cnt[i] + 1;
                    end
                    m_prev[i] = s;
                end
            end
        end
        if (a >= 0) begin
            m_pend[a] = 1'b0;
            m_last    = a;
            next_ok   = cyc + GAPC + 1;
        end
        m_pre = (!bus.enable || tk) ? 0 : m_pre + 1;
        if (bus.sample_valid) begin
            m_s[0] = $signed(bus.accel_x);
            m_s[1] = $signed(bus.accel_y);
        end
        cyc++;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic load(input int x, input int y);
        bus.accel_x      = 12'(x);
        bus.accel_y      = 12'(y);
        bus.sample_valid = 1'b1;
        cycle();
        bus.sample_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        model_clear();
        cycle();
        cycle();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        bus.enable = 1'b0; bus.sample_valid = 1'b0; bus.accel_x = '0; bus.accel_y = '0;
        #1 reset = 1'b0;
        model_clear();
        cycle();
        cycle();
        checks++;
        if (bus.movement !== 4'b0000 || bus.debug !== 8'h00) begin
            errors++;
            $display("FAIL reset_state movement=%b debug=%h required 0000/00", bus.movement, bus.debug);
        end
        reset = 1'b1;
        cycle();
        checks++;
        if (bus.debug !== 8'h00) begin
            errors++;
            $display("FAIL post_release debug=%h required 00", bus.debug);
        end
    endtask

    task automatic test_slow_right();
        int last_t = -1;
        bus.enable = 1'b1;
        load(100, 0);
        for (int c = 0; c < 700; c++) begin
            cycle();
            checks++;
            if (bus.movement !== exp_mov() || bus.debug !== exp_dbg()) begin
                errors++;
                $display("FAIL slow_right cyc=%0d movement=%b/%b debug=%h/%h", cyc, bus.movement, exp_mov(), bus.debug, exp_dbg());
            end
            if (bus.movement != 4'b0000) begin
                if (last_t >= 0) begin
                    checks++;
                    if (c - last_t != 160) begin
                        errors++;
                        $display("FAIL slow_right_spacing got %0d required 160", c - last_t);
                    end
                end
                last_t = c;
            end
        end
        checks++;
        if (last_t < 0) begin
            errors++;
            $display("FAIL slow_right_any got no pulse required at least one");
        end
    endtask

    task automatic test_fast_right();
        int last_t = -1;
        load(500, 0);
        checks++;
        if (bus.debug[7:6] !== 2'd3) begin
            errors++;
            $display("FAIL fast_level_x got %0d required 3", bus.debug[7:6]);
        end
        for (int c = 0; c < 600; c++) begin
            cycle();
            checks++;
            if (bus.movement !== exp_mov() || bus.debug !== exp_dbg()) begin
                errors++;
                $display("FAIL fast_right cyc=%0d movement=%b/%b debug=%h/%h", cyc, bus.movement, exp_mov(), bus.debug, exp_dbg());
            end
            if (bus.movement != 4'b0000) begin
                if (last_t >= 0) begin
                    checks++;
                    if (c - last_t != GAPC + 1) begin
                        errors++;
                        $display("FAIL fast_spacing got %0d required %0d", c - last_t, GAPC + 1);
                    end
                end
                last_t = c;
            end
        end
    endtask

    task automatic test_enable_off();
        bus.enable = 1'b0;
        for (int c = 0; c < 300; c++) begin
            cycle();
            checks++;
            if (bus.movement !== 4'b0000 || bus.debug !== exp_dbg()) begin
                errors++;
                $display("FAIL enable_off cyc=%0d movement=%b/0000 debug=%h/%h", cyc, bus.movement, bus.debug, exp_dbg());
            end
        end
        checks++;
        if (bus.debug[3:2] !== 2'b00) begin
            errors++;
            $display("FAIL enable_off_pending got %b required 00", bus.debug[3:2]);
        end
        bus.enable = 1'b1;
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            load($urandom_range(0, 4095) - 2048, $urandom_range(0, 4095) - 2048);
            for (int c = 0; c < 300; c++) begin
                cycle();
                checks++;
                if (bus.movement !== exp_mov() || bus.debug !== exp_dbg()) begin
                    errors++;
                    $display("FAIL random cyc=%0d movement=%b/%b debug=%h/%h", cyc, bus.movement, exp_mov(), bus.debug, exp_dbg());
                end
            end
        end
    endtask

    task automatic test_both_axes();
        int n = 0;
        logic [3:0] want;
        pulse_reset();
        load(-300, -300);
        for (int c = 0; c < 800; c++) begin
            cycle();
            checks++;
            if (bus.movement !== exp_mov() || bus.debug !== exp_dbg()) begin
                errors++;
                $display("FAIL both_axes cyc=%0d movement=%b/%b debug=%h/%h", cyc, bus.movement, exp_mov(), bus.debug, exp_dbg());
            end
            if (bus.movement != 4'b0000) begin
                want = (n % 2 == 0) ? 4'b0001 : 4'b0100;
                checks++;
                if (bus.movement !== want) begin
                    errors++;
                    $display("FAIL both_alternate pulse %0d got %b required %b", n, bus.movement, want);
                end
                n++;
            end
        end
        checks++;
        if (n < 4) begin
            errors++;
            $display("FAIL both_count got %0d required >= 4", n);
        end
    endtask

    task automatic test_deadzone();
        int last_t = -1;
        int lefts = 0;
        pulse_reset();
        for (int k = 0; k < 2; k++) begin
            load((k == 0) ? 64 : -64, 0);
            for (int c = 0; c < 1000; c++) begin
                cycle();
                checks++;
                if (bus.movement !== 4'b0000 || bus.debug !== exp_dbg()) begin
                    errors++;
                    $display("FAIL deadzone_edge cyc=%0d movement=%b/0000 debug=%h/%h", cyc, bus.movement, bus.debug, exp_dbg());
                end
            end
        end
        load(65, 0);
        for (int c = 0; c < 700; c++) begin
            cycle();
            checks++;
            if (bus.movement !== exp_mov() || bus.debug !== exp_dbg()) begin
                errors++;
                $display("FAIL deadzone_65 cyc=%0d movement=%b/%b debug=%h/%h", cyc, bus.movement, exp_mov(), bus.debug, exp_dbg());
            end
            if (bus.movement != 4'b0000) begin
                if (last_t >= 0) begin
                    checks++;
                    if (c - last_t != 160) begin
                        errors++;
                        $display("FAIL deadzone_65_spacing got %0d required 160", c - last_t);
                    end
                end
                last_t = c;
            end
        end
        load(-2048, 0);
        checks++;
        if (bus.debug[7:6] !== 2'd3) begin
            errors++;
            $display("FAIL min_neg_level got %0d required 3", bus.debug[7:6]);
        end
        for (int c = 0; c < 300; c++) begin
            cycle();
            checks++;
            if (bus.movement !== exp_mov() || bus.debug !== exp_dbg()) begin
                errors++;
                $display("FAIL min_neg cyc=%0d movement=%b/%b debug=%h/%h", cyc, bus.movement, exp_mov(), bus.debug, exp_dbg());
            end
            if (bus.movement == 4'b0100) lefts++;
        end
        checks++;
        if (lefts == 0) begin
            errors++;
            $display("FAIL min_neg_left got 0 LEFT pulses required >= 1");
        end
    endtask

    task automatic test_sign_flip();
        int first_t = -1;
        pulse_reset();
        load(100, 0);
        repeat (99) cycle();
        load(-100, 0);
        for (int c = 0; c < 200; c++) begin
            cycle();
            checks++;
            if (bus.movement !== exp_mov() || bus.debug !== exp_dbg()) begin
                errors++;
                $display("FAIL sign_flip cyc=%0d movement=%b/%b debug=%h/%h", cyc, bus.movement, exp_mov(), bus.debug, exp_dbg());
            end
            if (bus.movement != 4'b0000 && first_t < 0) begin
                first_t = c;
                checks++;
                if (bus.movement !== 4'b0100) begin
                    errors++;
                    $display("FAIL sign_flip_dir got %b required 0100", bus.movement);
                end
            end
        end
        checks++;
        if (first_t < 150 || first_t > 170) begin
            errors++;
            $display("FAIL sign_flip_latency got %0d required 150..170", first_t);
        end
    endtask

    task automatic test_reset_in_gap();
        bit found = 1'b0;
        pulse_reset();
        load(0, -500);
        for (int c = 0; c < 300 && !found; c++) begin
            cycle();
            checks++;
            if (bus.movement !== exp_mov() || bus.debug !== exp_dbg()) begin
                errors++;
                $display("FAIL gap_wait cyc=%0d movement=%b/%b debug=%h/%h", cyc, bus.movement, exp_mov(), bus.debug, exp_dbg());
            end
            if (bus.movement != 4'b0000) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL gap_timeout got no pulse in 300 cycles required one");
        end
        repeat (60) cycle();
        checks++;
        if (bus.debug[2] !== 1'b1 || bus.debug[0] !== 1'b1) begin
            errors++;
            $display("FAIL gap_pending_y debug=%h required pending_y=1 in_gap=1", bus.debug);
        end
        #2 reset = 1'b0;
        model_clear();
        #1;
        checks++;
        if (bus.movement !== 4'b0000 || bus.debug !== 8'h00) begin
            errors++;
            $display("FAIL async_reset movement=%b debug=%h required 0000/00", bus.movement, bus.debug);
        end
        bus.accel_y = '0;
        cycle();
        cycle();
        reset = 1'b1;
        for (int c = 0; c < 1000; c++) begin
            cycle();
            checks++;
            if (bus.movement !== 4'b0000 || bus.debug !== exp_dbg()) begin
                errors++;
                $display("FAIL after_reset cyc=%0d movement=%b/0000 debug=%h/%h", cyc, bus.movement, bus.debug, exp_dbg());
            end
        end
    endtask

    initial begin
        test_reset();
        test_slow_right();
        test_fast_right();
        test_enable_off();
        test_random();
        test_both_axes();
        test_deadzone();
        test_sign_flip();
        test_reset_in_gap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/tilt_to_move.md
Name: tilt_to_move

Overview:
- Upstream stage of the ball block; converts signed accelerometer tilt samples into the one-hot `movement` pulses the ball consumes.
- Applies a per-axis deadzone and maps tilt magnitude to a step rate (steeper tilt gives faster steps).
- Arbitrates X/Y steps onto a single one-hot output.
- Enforces a minimum pulse spacing so the ball's pixel-validation sequence always finishes before the next request.

Parameters:
- ACCEL_WIDTH, 12: width of signed two's-complement accel inputs.
- DEADZONE, 64: |tilt| <= DEADZONE produces no motion on that axis.
- LEVEL_SHIFT, 7: level = min(3, (|tilt| - DEADZONE) >> LEVEL_SHIFT).
- TICK_CYCLES, 100000: clocks per rate tick (1 ms at 100 MHz).
- SIMULATE, 0: 1 selects SIMULATE_TICK_CYCLES instead of TICK_CYCLES.
- SIMULATE_TICK_CYCLES, 5: tick length in simulation.
- MAX_INTERVAL, 32: ticks per step at level 0; interval = MAX_INTERVAL >> level.
- MIN_GAP, 128: idle clocks forced after every output pulse; must exceed the ball's worst-case check time of about 15*4+3 clocks.
- INVERT_X, 0: 1 swaps LEFT/RIGHT.
- INVERT_Y, 0: 1 swaps UP/DOWN.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset.
- enable  in  1  1 = run; 0 = freeze and clear all motion state.
- sample_valid  in  1  one-cycle strobe; accel_x/accel_y are valid.
- accel_x  in  ACCEL_WIDTH  signed X tilt.
- accel_y  in  ACCEL_WIDTH  signed Y tilt.
- movement  out  4  one-hot step request: UP=0001, DOWN=0010, LEFT=0100, RIGHT=1000; at most one bit set, one clock wide.
- debug  out  8  {level_x[1:0], level_y[1:0], pending_x, pending_y, last_axis, in_gap}.

Behaviour:
- Reset:
  - Single clock domain `clk`. `reset` is asynchronous and active-low.
  - While reset is low: movement=0, debug=0, latched samples=0, prescaler=0, axis counters=0, pending flags=0, last_axis=0 (X), arbiter state=IDLE.
  - Reset asserted mid-gap or mid-count clears everything immediately. There is no pulse on deassertion.
- Sample latch:
  - On sample_valid, accel_x/accel_y are registered and used from the next clock.
  - Before the first sample the latched values are 0, which is inside the deadzone.
- Magnitude:
  - |v| computed unsigned, ACCEL_WIDTH bits; the most negative value (-2048) maps to 2048 without overflow.
  - Dead if |v| <= DEADZONE.
  - level and interval as defined in Parameters; interval is never 0 for MAX_INTERVAL >= 8.
- Direction:
  - X: v>0 -> RIGHT, v<0 -> LEFT.
  - Y: v>0 -> DOWN, v<0 -> UP.
  - INVERT_X / INVERT_Y swap the pair.
- Prescaler: counts 0..TICK_CYCLES-1 and issues a one-clock tick at wrap.
- Per-axis counter, on each tick:
  - Dead: counter=0, pending cleared.
  - Sign differs from the previous tick's live sign: counter=1, pending cleared.
  - Otherwise: counter+1. When counter+1 >= interval, counter=0, pending=1, and the direction is latched.
  - A level change takes effect on the next tick with no counter reset.
  - If the counter expires while already pending, pending stays 1 with the direction updated. There is no queueing and no double step.
- Arbiter FSM:
  - IDLE: if exactly one pending flag is set, emit that axis's direction on movement for 1 clock, clear its pending flag, record last_axis, and go to GAP.
  - IDLE with both pending: emit the axis opposite to last_axis (alternating priority).
  - GAP: movement=0 for MIN_GAP clocks, then IDLE.
  - Resulting pulse spacing is >= MIN_GAP+1 clocks.
- Latency: a pulse appears the clock after the tick that sets pending, if the arbiter is in IDLE.
- Pending set and emitted in the same cycle: set wins for the other axis; the emitted axis clears.
- enable=0:
  - Synchronously clears counters, pending flags and the prescaler.
  - movement forced 0.
  - Gap counter allowed to finish.
  - Sample latching continues.

Test Plan:
- SIMULATE=1 (tick=5 clks), accel_x=+100, accel_y=0 -> level 0, interval 32 ticks. RIGHT (1000) pulses every 160 clks, each exactly 1 clk wide; no other bits.
- accel_x=+500 -> level 3, interval 4 ticks (20 clks). Pending every 20 clks, but pulses are spaced exactly MIN_GAP+1=129 clks; debug level_x=3.
- accel_x=-300, accel_y=-300 (both level 1, interval 16) -> pulses alternate LEFT(0100) and UP(0001), starting with Y since last_axis resets to X. movement is never multi-hot.
- Deadzone edge: accel_x=+64 or -64 -> no pulse for 1000 clks. accel_x=+65 -> RIGHT pulses resume at 160-clk spacing. accel_x=-2048 -> LEFT with level 3.
- Sign flip: accel_x=+100 for 20 ticks, then -100 -> no pulse at the old expiry; first LEFT pulse 32 ticks after the flip tick.
- Reset low during GAP with pending_y=1 -> movement=0 and debug=0 asynchronously. After release with accel_y=0, no pulse is ever emitted.
